fetch: RTL and testbench

FETCH -- requirements
Module: fetch

---
 rtl/fetch.sv | 182 ++++++++++++++++++
 tb/tb_fetch.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch.sv
// ---------------------------------------------------------------------------
// fetch -- instruction fetch stage with a two-entry in-order fetch buffer.
//
// Issues sequential instruction-memory requests starting at RESET_PC. Each
// granted request takes a buffer slot. The slot is marked pending until its
// in-order response arrives. Filled slots are then handed to the IF/ID
// register in program order. A redirect drops every slot. It also records how
// many responses are still owed, so those responses can be discarded when they
// arrive.
//
// Ports
//   clk_i          rising-edge clock
//   rst_i          synchronous active-high reset
//   stallF_i       hold the IF/ID register (the buffer keeps filling)
//   redirect_i     taken branch/jump: flush and restart at redirect_pc_i
//   redirect_pc_i  redirect target (low two bits ignored)
//   imem_req_o     instruction-memory request
//   imem_addr_o    request address (the next fetch PC)
//   imem_gnt_i     request accepted this cycle
//   imem_rvalid_i  in-order response valid
//   imem_rdata_i   response instruction
//   pcF_o          IF/ID PC
//   instrF_o       IF/ID instruction (NOP when not valid)
//   validF_o       IF/ID holds a real instruction
// ---------------------------------------------------------------------------
module fetch #(
  parameter int unsigned      XLEN      = 32,
  parameter logic [XLEN-1:0]  RESET_PC  = '0,
  parameter int unsigned      BUF_DEPTH = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            stallF_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic [XLEN-1:0] pcF_o,
  output logic [XLEN-1:0] instrF_o,
  output logic            validF_o
);

  localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

  // Buffer state: slots are used as a ring starting at r_head. Responses come
  // back in order, so the filled slots always precede the pending ones.
  logic [XLEN-1:0] r_pc_q;
  logic [1:0]      r_alloc;
  logic [1:0]      r_filled;
  logic [XLEN-1:0] r_ent_pc  [2];
  logic [XLEN-1:0] r_ent_ins [2];
  logic            r_head;
  logic [1:0]      r_kill_cnt;
  logic [XLEN-1:0] r_pcF;
  logic [XLEN-1:0] r_instrF;
  logic            r_validF;

  logic [1:0]      w_n_alloc;
  logic [1:0]      w_n_filled;
  logic [1:0]      w_n_pend;
  logic [2:0]      w_occupancy;
  logic            w_tail_idx;
  logic            w_pend_idx;
  logic            w_gnt;
  logic            w_kill_hit;
  logic            w_fill;
  logic            w_head_ready;
  logic [XLEN-1:0] w_head_instr;
  logic            w_pop;
  logic [2:0]      w_kill_sum;
  logic [1:0]      w_kill_redir;
  logic [XLEN-1:0] w_redir_pc;
  logic [1:0]      w_pop_sel;
  logic [1:0]      w_push_sel;
  logic [1:0]      w_fill_sel;

  assign w_n_alloc   = {1'b0, r_alloc[0]} + {1'b0, r_alloc[1]};
  assign w_n_filled  = {1'b0, r_filled[0]} + {1'b0, r_filled[1]};
  assign w_n_pend    = w_n_alloc - w_n_filled;
  assign w_occupancy = {1'b0, w_n_alloc} + {1'b0, r_kill_cnt};

  // Killed responses still hold a memory slot, so they count against the
  // request budget just like allocated entries.
  assign imem_req_o  = !rst_i && (w_occupancy < 3'(BUF_DEPTH));
  assign imem_addr_o = r_pc_q;

  // A grant only happens when fewer than two slots are allocated. The tail
  // slot is therefore head+count. The oldest pending slot follows the filled ones.
  assign w_tail_idx  = r_head ^ w_n_alloc[0];
  assign w_pend_idx  = r_head ^ w_n_filled[0];

  assign w_gnt       = imem_req_o & imem_gnt_i;
  assign w_kill_hit  = imem_rvalid_i & (r_kill_cnt != 2'd0);
  assign w_fill      = imem_rvalid_i & (r_kill_cnt == 2'd0) & (w_n_pend != 2'd0);

  // Bypass: the head may be filled by this cycle's response.
  assign w_head_ready = r_filled[r_head] | (w_fill & (w_pend_idx == r_head));
  assign w_head_instr = r_filled[r_head] ? r_ent_ins[r_head] : imem_rdata_i;
  assign w_pop        = !stallF_i & !redirect_i & w_head_ready;

  // On redirect, every response still owed must be discarded. That covers
  // responses already marked killed, pending slots and a grant taken this cycle.
  // A response consumed this cycle is one fewer to discard.
  assign w_kill_sum   = {1'b0, r_kill_cnt} + {1'b0, w_n_pend} + {2'b00, w_gnt}
                      - {2'b00, (w_fill | w_kill_hit)};
  assign w_kill_redir = (w_kill_sum > 3'd2) ? 2'd2 : w_kill_sum[1:0];
  assign w_redir_pc   = redirect_pc_i & ~XLEN'(3);

  for (genvar gi = 0; gi < 2; gi++) begin : g_ent
    assign w_pop_sel[gi]  = w_pop  & (r_head     == 1'(gi));
    assign w_push_sel[gi] = w_gnt  & (w_tail_idx == 1'(gi));
    assign w_fill_sel[gi] = w_fill & (w_pend_idx == 1'(gi));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pc_q     <= RESET_PC;
      r_alloc    <= '0;
      r_filled   <= '0;
      r_head     <= 1'b0;
      r_kill_cnt <= 2'd0;
      r_pcF      <= '0;
      r_instrF   <= NOP;
      r_validF   <= 1'b0;
    end else if (redirect_i) begin
      // A grant in this cycle is for the old path. It only adds to the kill count.
      r_pc_q     <= w_redir_pc;
      r_alloc    <= '0;
      r_filled   <= '0;
      r_head     <= 1'b0;
      r_kill_cnt <= w_kill_redir;
      r_pcF      <= '0;
      r_instrF   <= NOP;
      r_validF   <= 1'b0;
    end else begin
      if (w_kill_hit) begin
        r_kill_cnt <= r_kill_cnt - 2'd1;
      end
      for (int i = 0; i < 2; i++) begin
        if (w_fill_sel[i]) begin
          r_filled[i]  <= 1'b1;
          r_ent_ins[i] <= imem_rdata_i;
        end
        if (w_push_sel[i]) begin
          r_alloc[i]  <= 1'b1;
          r_filled[i] <= 1'b0;
          r_ent_pc[i] <= r_pc_q;
        end
        // Popping the head overrides a same-cycle fill of that slot (bypass).
        if (w_pop_sel[i]) begin
          r_alloc[i]  <= 1'b0;
          r_filled[i] <= 1'b0;
        end
      end
      if (w_pop) begin
        r_head <= ~r_head;
      end
      if (w_gnt) begin
        r_pc_q <= r_pc_q + XLEN'(4);
      end
      if (!stallF_i) begin
        if (w_head_ready) begin
          r_pcF    <= r_ent_pc[r_head];
          r_instrF <= w_head_instr;
          r_validF <= 1'b1;
        end else begin
          r_pcF    <= '0;
          r_instrF <= NOP;
          r_validF <= 1'b0;
        end
      end
    end
  end

  assign pcF_o    = r_pcF;
  assign instrF_o = r_instrF;
  assign validF_o = r_validF;

endmodule

// File: tb/tb_fetch.sv
// ---------------------------------------------------------------------------
// tb_fetch -- self-checking bench for fetch.
//
// A queue-based reference model tracks buffered instructions and outstanding
// responses (live or killed). It predicts the request, address and IF/ID
// outputs every cycle. A simple memory returns in-order responses whose data
// equals the request address. Directed scenarios pin the model with literal
// expectations. A randomized phase then runs.
// ---------------------------------------------------------------------------
module tb_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        stallF_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] pcF_o;
  logic [31:0] instrF_o;
  logic        validF_o;

  always #5 clk = ~clk;

  fetch #(.XLEN(32), .RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .stallF_i      (stallF_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .pcF_o         (pcF_o),
    .instrF_o      (instrF_o),
    .validF_o      (validF_o)
  );

  int checks = 0;
  int errors = 0;
  bit check_en  = 1'b0;
  bit mem_flush = 1'b0;
  bit verbose   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- memory: in-order responses, data = address -------------
  logic [31:0] mem_q[$];

  always @(posedge clk) begin
    if (rst_i && mem_flush) begin
      mem_q.delete();
    end else begin
      if (imem_rvalid_i && mem_q.size() > 0) void'(mem_q.pop_front());
      if (imem_req_o && imem_gnt_i) mem_q.push_back(imem_addr_o);
    end
  end

  // ---------------- reference model ----------------------------------------
  typedef struct {
    logic [31:0] pc;
    bit          filled;
    logic [31:0] instr;
    int          id;
  } ent_t;

  ent_t        buf_q[$];
  int          out_q[$];    // outstanding responses in order; -1 = killed
  int          next_id = 0;
  logic [31:0] m_pc;
  logic [31:0] m_pcF;
  logic [31:0] m_instrF;
  bit          m_validF;
  bit          m_g;
  int          m_id;

  function automatic int killed_cnt();
    int c = 0;
    foreach (out_q[k]) if (out_q[k] < 0) c++;
    return c;
  endfunction

  always @(posedge clk) begin
    if (rst_i) begin
      m_pc = 32'h0;
      buf_q.delete();
      out_q.delete();
      m_pcF = 32'h0; m_instrF = NOP; m_validF = 1'b0;
    end else begin
      m_g = ((buf_q.size() + killed_cnt()) < 2) && imem_gnt_i;
      if (imem_rvalid_i && out_q.size() > 0) begin
        m_id = out_q.pop_front();
        if (m_id >= 0)
          foreach (buf_q[k])
            if (buf_q[k].id == m_id) begin
              buf_q[k].filled = 1'b1;
              buf_q[k].instr  = imem_rdata_i;
            end
      end
      if (redirect_i) begin
        foreach (out_q[k]) out_q[k] = -1;
        if (m_g) out_q.push_back(-1);
        buf_q.delete();
        m_pc = redirect_pc_i & 32'hFFFF_FFFC;
        m_pcF = 32'h0; m_instrF = NOP; m_validF = 1'b0;
      end else begin
        if (!stallF_i) begin
          if (buf_q.size() > 0 && buf_q[0].filled) begin
            m_pcF = buf_q[0].pc; m_instrF = buf_q[0].instr; m_validF = 1'b1;
            void'(buf_q.pop_front());
          end else begin
            m_pcF = 32'h0; m_instrF = NOP; m_validF = 1'b0;
          end
        end
        if (m_g) begin
          buf_q.push_back('{pc: m_pc, filled: 1'b0, instr: 32'h0, id: next_id});
          out_q.push_back(next_id);
          next_id++;
          m_pc = m_pc + 32'd4;
        end
      end
    end
  end

  // ---------------- per-cycle compare ---------------------------------------
  always @(negedge clk) begin
    #2;
    if (check_en) begin
      chk("model_req", {31'b0, imem_req_o},
          {31'b0, (!rst_i && ((buf_q.size() + killed_cnt()) < 2))});
      chk("model_addr",   imem_addr_o, m_pc);
      chk("model_validF", {31'b0, validF_o}, {31'b0, m_validF});
      chk("model_pcF",    pcF_o, m_pcF);
      chk("model_instrF", instrF_o, m_instrF);
      if (verbose && validF_o)
        $display("IF/ID pc=%h instr=%h", pcF_o, instrF_o);
    end
  end

  // ---------------- stimulus -------------------------------------------------
  // Drive gnt/rvalid for the coming edge, then move to 3 ns after the next negedge.
  task automatic cyc(input int gp, input int rp);
    imem_gnt_i = ($urandom_range(99) < gp);
    if (mem_q.size() > 0 && $urandom_range(99) < rp) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = mem_q[0];
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = $urandom;
    end
    @(negedge clk); #3;
  endtask

  initial begin
    rst_i = 1'b1; stallF_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
    verbose = 1'b1;
    @(negedge clk); #3;
    cyc(0, 0);
    check_en = 1'b1;

    // reset state
    chk("rst_validF", {31'b0, validF_o}, 32'd0);
    chk("rst_pcF", pcF_o, 32'h0);
    chk("rst_instrF", instrF_o, NOP);
    chk("rst_req", {31'b0, imem_req_o}, 32'd0);

    // sequential fetch, 1-cycle response latency
    rst_i = 1'b0; #1;
    chk("seq_req0", {31'b0, imem_req_o}, 32'd1);
    chk("seq_addr0", imem_addr_o, 32'h0);
    cyc(100, 100);
    chk("seq_addr1", imem_addr_o, 32'h4);
    cyc(100, 100);
    chk("seq_addr2", imem_addr_o, 32'h8);
    chk("seq_valid", {31'b0, validF_o}, 32'd1);
    chk("seq_pcF", pcF_o, 32'h0);
    chk("seq_instr", instrF_o, 32'h0);

    // stall 3 cycles
    stallF_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc(100, 100);
      chk("stall_pcF_held", pcF_o, 32'h0);
      chk("stall_req_drop", {31'b0, imem_req_o}, 32'd0);
    end
    stallF_i = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      cyc(100, 100);
      chk("stall_release_pcF", pcF_o, 32'(4 * k));
      chk("stall_release_instr", instrF_o, 32'(4 * k));
    end

    // redirect with two responses pending
    cyc(100, 0);
    chk("redir_full_req", {31'b0, imem_req_o}, 32'd0);
    redirect_i = 1'b1; redirect_pc_i = 32'h100;
    cyc(100, 0);
    redirect_i = 1'b0;
    chk("redir_validF", {31'b0, validF_o}, 32'd0);
    chk("redir_addr", imem_addr_o, 32'h100);
    chk("redir_req_killed", {31'b0, imem_req_o}, 32'd0);
    cyc(100, 100);
    chk("redir_req_after1", {31'b0, imem_req_o}, 32'd1);
    cyc(100, 100);
    chk("redir_no_stale", {31'b0, validF_o}, 32'd0);
    cyc(100, 100);
    chk("redir_first_pc", pcF_o, 32'h100);
    chk("redir_first_valid", {31'b0, validF_o}, 32'd1);

    // redirect to an unaligned target in the same cycle as a grant and an rvalid
    redirect_i = 1'b1; redirect_pc_i = 32'h102;
    cyc(100, 100);
    redirect_i = 1'b0;
    chk("redir2_addr", imem_addr_o, 32'h100);
    chk("redir2_validF", {31'b0, validF_o}, 32'd0);
    cyc(100, 100);
    chk("redir2_no_stale", {31'b0, validF_o}, 32'd0);
    chk("redir2_kill_settled", {31'b0, imem_req_o}, 32'd1);
    cyc(100, 100);
    chk("redir2_pcF", pcF_o, 32'h100);
    chk("redir2_instr", instrF_o, 32'h100);

    // address wrap
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
    cyc(100, 100);
    redirect_i = 1'b0;
    chk("wrap_addr_top", imem_addr_o, 32'hFFFF_FFFC);
    for (int k = 0; k < 8 && imem_addr_o == 32'hFFFF_FFFC; k++) cyc(100, 100);
    chk("wrap_addr_zero", imem_addr_o, 32'h0);
    cyc(100, 100);
    chk("wrap_pcF", pcF_o, 32'hFFFF_FFFC);

    // reset with two responses in flight; strays arrive afterwards
    cyc(100, 0);
    chk("rst2_inflight_req", {31'b0, imem_req_o}, 32'd0);
    rst_i = 1'b1;
    cyc(0, 0);
    chk("rst2_validF", {31'b0, validF_o}, 32'd0);
    chk("rst2_instrF", instrF_o, NOP);
    chk("rst2_pcF", pcF_o, 32'h0);
    rst_i = 1'b0; #1;
    chk("rst2_req", {31'b0, imem_req_o}, 32'd1);
    for (int k = 0; k < 2; k++) begin
      cyc(0, 100);
      chk("rst2_stray_ignored", {31'b0, validF_o}, 32'd0);
    end
    cyc(100, 100);
    cyc(100, 100);
    chk("rst2_refetch_valid", {31'b0, validF_o}, 32'd1);
    chk("rst2_refetch_pc", pcF_o, 32'h0);
    $display("directed scenarios done");

    // randomized phase
    verbose = 1'b0;
    mem_flush = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      rst_i         = ($urandom_range(199) == 0);
      stallF_i      = ($urandom_range(99) < 20);
      redirect_i    = ($urandom_range(99) < 6);
      redirect_pc_i = ($urandom_range(3) == 0) ? 32'hFFFF_FFF8 : $urandom;
      cyc(70, 60);
    end
    rst_i = 1'b0; stallF_i = 1'b0; redirect_i = 1'b0;
    for (int c = 0; c < 10; c++) cyc(100, 100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
